// File: rtl/gps_ca_replica_if.sv
// Control and replica-output bundle between the chip-rate NCO/tracking
// controller and the GPS L1 C/A replica generator.
interface gps_ca_replica_if;
    logic       chip_en;
    logic       start;
    logic       stop;
    logic       retune;
    logic [3:0] sel_a;
    logic [3:0] sel_b;
    logic       ca_e;
    logic       ca_p;
    logic       ca_l;
    logic [9:0] chip_idx;
    logic       epoch;
    logic       bit_edge;
    logic       busy;

    // Controller side: drives strobes and tap selects, observes the replica.
    modport master (
        output chip_en, start, stop, retune, sel_a, sel_b,
        input  ca_e, ca_p, ca_l, chip_idx, epoch, bit_edge, busy
    );

    // Generator side.
    modport slave (
        input  chip_en, start, stop, retune, sel_a, sel_b,
        output ca_e, ca_p, ca_l, chip_idx, epoch, bit_edge, busy
    );
endinterface

// File: rtl/gps_ca_replica.sv
// GPS L1 C/A Gold-code replica generator: G1/G2 LFSRs with runtime G2
// phase-selector taps, chip-rate advance, epoch-aligned retune and
// early/prompt/late outputs taken from a chip-shifted delay line.
module gps_ca_replica #(
    parameter int SPACING        = 1,
    parameter int EPOCHS_PER_BIT = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    gps_ca_replica_if.slave  bus
);
    localparam int         DLY_LEN   = 2 * SPACING;
    localparam logic [9:0] LAST_CHIP = 10'd1022;
    localparam logic [5:0] EPB_LAST  = 6'(EPOCHS_PER_BIT - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q;
    state_t              state_d;
    logic [10:1]         g1_q;
    logic [10:1]         g2_q;
    logic [3:0]          tap_a_q;
    logic [3:0]          tap_b_q;
    logic [3:0]          pend_a_q;
    logic [3:0]          pend_b_q;
    logic [9:0]          idx_q;
    logic [DLY_LEN-1:0]  dly_q;
    logic [5:0]          ep_cnt_q;
    logic                epoch_q;
    logic                bit_edge_q;

    logic                restart;
    logic                advance;
    logic                wrap;
    logic                take_retune;
    logic                chip_val;
    logic [10:1]         g1_next;
    logic [10:1]         g2_next;

    // A tap outside stages 1..10 contributes nothing to the chip.
    function automatic logic g2_tap(input logic [10:1] g, input logic [3:0] t);
        logic v;
        v = 1'b0;
        case (t)
            4'd1:    v = g[1];
            4'd2:    v = g[2];
            4'd3:    v = g[3];
            4'd4:    v = g[4];
            4'd5:    v = g[5];
            4'd6:    v = g[6];
            4'd7:    v = g[7];
            4'd8:    v = g[8];
            4'd9:    v = g[9];
            4'd10:   v = g[10];
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    // Current chip and the one-step LFSR successors (stage k -> k+1, feedback into stage 1).
    always_comb begin
        chip_val = g1_q[10] ^ g2_tap(g2_q, tap_a_q) ^ g2_tap(g2_q, tap_b_q);
        g1_next  = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
        g2_next  = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
    end

    // Run/idle state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control strobes; start outranks stop, which outranks chip_en.
    always_comb begin
        state_d     = state_q;
        restart     = 1'b0;
        advance     = 1'b0;
        wrap        = 1'b0;
        take_retune = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    restart = 1'b1;
                end
            end
            RUN: begin
                if (bus.start) begin
                    restart = 1'b1;
                end else if (bus.stop) begin
                    state_d = IDLE;
                end else begin
                    take_retune = bus.retune;
                    advance     = bus.chip_en;
                    wrap        = bus.chip_en && (idx_q == LAST_CHIP);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Code generator, tap registers, delay line and epoch/bit counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g1_q       <= '1;
            g2_q       <= '1;
            tap_a_q    <= '0;
            tap_b_q    <= '0;
            pend_a_q   <= '0;
            pend_b_q   <= '0;
            idx_q      <= '0;
            dly_q      <= '0;
            ep_cnt_q   <= '0;
            epoch_q    <= 1'b0;
            bit_edge_q <= 1'b0;
        end else if (restart) begin
            g1_q       <= '1;
            g2_q       <= '1;
            tap_a_q    <= bus.sel_a;
            tap_b_q    <= bus.sel_b;
            pend_a_q   <= bus.sel_a;
            pend_b_q   <= bus.sel_b;
            idx_q      <= '0;
            dly_q      <= '0;
            ep_cnt_q   <= '0;
            epoch_q    <= 1'b0;
            bit_edge_q <= 1'b0;
        end else begin
            epoch_q    <= 1'b0;
            bit_edge_q <= 1'b0;
            if (take_retune) begin
                pend_a_q <= bus.sel_a;
                pend_b_q <= bus.sel_b;
            end
            if (advance) begin
                dly_q <= {dly_q[DLY_LEN-2:0], chip_val};
                if (wrap) begin
                    // A retune arriving with the wrapping strobe is used from chip 0 onward.
                    g1_q    <= '1;
                    g2_q    <= '1;
                    idx_q   <= '0;
                    tap_a_q <= take_retune ? bus.sel_a : pend_a_q;
                    tap_b_q <= take_retune ? bus.sel_b : pend_b_q;
                    epoch_q <= 1'b1;
                    if (ep_cnt_q == EPB_LAST) begin
                        ep_cnt_q   <= '0;
                        bit_edge_q <= 1'b1;
                    end else begin
                        ep_cnt_q <= ep_cnt_q + 6'd1;
                    end
                end else begin
                    g1_q  <= g1_next;
                    g2_q  <= g2_next;
                    idx_q <= idx_q + 10'd1;
                end
            end
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.ca_e     = (state_q == RUN) & chip_val;
    assign bus.ca_p     = (state_q == RUN) & dly_q[SPACING-1];
    assign bus.ca_l     = (state_q == RUN) & dly_q[DLY_LEN-1];
    assign bus.chip_idx = idx_q;
    assign bus.epoch    = epoch_q;
    assign bus.bit_edge = bit_edge_q;
endmodule

// File: tb/tb_gps_ca_replica.sv
// Scoreboard bench for gps_ca_replica: stimulus pushes expected output
// vectors into a queue, a monitor pops and compares them one cycle later.
module tb_gps_ca_replica;
    localparam int SPACING = 2;
    localparam int EPB     = 3;

    typedef struct packed {
        int          cyc;
        int          kind;
        logic [15:0] val;
        logic [15:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    gps_ca_replica_if bus();

    gps_ca_replica #(.SPACING(SPACING), .EPOCHS_PER_BIT(EPB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp   = 0;
    int    n_fail  = 0;
    int    cycle   = 0;
    int    ep_seen = 0;
    int    be_seen = 0;
    bit    count_en = 1'b0;

    bit    code_tab[2][1023];
    logic  m_busy;
    int    m_idx;
    int    m_act;
    int    m_pend;
    int    m_cnt;
    logic [2*SPACING-1:0] m_dly;
    logic  m_ep;
    logic  m_be;

    logic [9:0] prn1_first;
    logic [9:0] prn2_first;

    exp_t        mon_e;
    string       mon_nm;
    logic [15:0] mon_got;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference code from the LFSR definitions, built once per tap pair.
    task automatic gen_code(input int ta, input int tb, input int which);
        bit g1[1:10];
        bit g2[1:10];
        bit f1;
        bit f2;
        for (int k = 1; k <= 10; k++) begin
            g1[k] = 1'b1;
            g2[k] = 1'b1;
        end
        for (int i = 0; i < 1023; i++) begin
            code_tab[which][i] = g1[10] ^ g2[ta] ^ g2[tb];
            f1 = g1[3] ^ g1[10];
            f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
            for (int k = 10; k >= 2; k--) begin
                g1[k] = g1[k-1];
                g2[k] = g2[k-1];
            end
            g1[1] = f1;
            g2[1] = f2;
        end
    endtask

    function automatic int prn_of(input logic [3:0] a, input logic [3:0] b);
        return (a == 4'd2 && b == 4'd6) ? 0 : 1;
    endfunction

    function automatic logic m_e();
        return m_busy ? logic'(code_tab[m_act][m_idx]) : 1'b0;
    endfunction

    function automatic logic [15:0] exp_vec();
        return {m_busy, m_ep, m_be, m_e(), m_busy & m_dly[SPACING-1],
                m_busy & m_dly[2*SPACING-1], 10'(m_idx)};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {bus.busy, bus.epoch, bus.bit_edge, bus.ca_e, bus.ca_p, bus.ca_l, bus.chip_idx};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_idx  = 0;
        m_act  = 0;
        m_pend = 0;
        m_cnt  = 0;
        m_dly  = '0;
        m_ep   = 1'b0;
        m_be   = 1'b0;
    endtask

    task automatic push_exp(input string nm, input logic [15:0] val, input logic [15:0] mask,
                            input int kind, input int at);
        exp_t e;
        e.cyc  = at;
        e.kind = kind;
        e.val  = val;
        e.mask = mask;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic check_output(input string nm, input logic [15:0] got,
                                input logic [15:0] want, input logic [15:0] mask);
        n_cmp++;
        if ((got & mask) !== (want & mask)) begin
            n_fail++;
            $display("[TB] FAIL %s: got %04h required %04h (mask %04h, bits busy/ep/be/e/p/l/idx) cycle %0d",
                     nm, got, want, mask, cycle);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and advance the model to the post-edge state.
    task automatic apply_stimulus(input logic ce, input logic st, input logic sp, input logic rt,
                                  input logic [3:0] a, input logic [3:0] b,
                                  input bit chk, input string nm);
        @(negedge clk);
        bus.chip_en = ce;
        bus.start   = st;
        bus.stop    = sp;
        bus.retune  = rt;
        bus.sel_a   = a;
        bus.sel_b   = b;
        m_ep = 1'b0;
        m_be = 1'b0;
        if (st) begin
            m_busy = 1'b1;
            m_idx  = 0;
            m_act  = prn_of(a, b);
            m_pend = m_act;
            m_dly  = '0;
            m_cnt  = 0;
        end else if (m_busy) begin
            if (sp) begin
                m_busy = 1'b0;
            end else begin
                if (rt) m_pend = prn_of(a, b);
                if (ce) begin
                    m_dly = {m_dly[2*SPACING-2:0], m_e()};
                    if (m_idx == 1022) begin
                        m_idx = 0;
                        m_act = m_pend;
                        m_ep  = 1'b1;
                        m_cnt++;
                        if (m_cnt == EPB) begin
                            m_cnt = 0;
                            m_be  = 1'b1;
                        end
                    end else begin
                        m_idx++;
                    end
                end
            end
        end
        if (chk) push_exp(nm, exp_vec(), 16'hFFFF, 0, cycle + 1);
    endtask

    // Chips 1..9 after a fresh start, checked against a hand-written 10-chip prefix.
    task automatic hand_chips(input string nm, input logic [9:0] first,
                              input logic [3:0] a, input logic [3:0] b);
        logic e;
        logic p;
        logic l;
        for (int k = 1; k < 10; k++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, a, b, 1'b0, "");
            e = first[9-k];
            p = (k >= 2) ? first[11-k] : 1'b0;
            l = (k >= 4) ? first[13-k] : 1'b0;
            push_exp($sformatf("%s%0d", nm, k), {1'b1, 2'b00, e, p, l, 10'(k)}, 16'hFFFF, 0, cycle + 1);
        end
    endtask

    // Monitor: pops every expectation due by now and compares it with the DUT.
    always begin
        @(posedge clk or negedge reset_n);
        #1;
        if (count_en) begin
            if (bus.epoch === 1'b1) ep_seen++;
            if (bus.bit_edge === 1'b1) be_seen++;
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            if (mon_e.cyc < cycle) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL %s: expectation for cycle %0d was not sampled (now %0d)",
                         mon_nm, mon_e.cyc, cycle);
            end else if (mon_e.kind == 1) begin
                mon_got = {8'(ep_seen), 8'(be_seen)};
                check_output(mon_nm, mon_got, mon_e.val, mon_e.mask);
            end else begin
                mon_got = dut_vec();
                check_output(mon_nm, mon_got, mon_e.val, mon_e.mask);
            end
        end
    end

    initial begin
        prn1_first  = 10'b1100100000;
        prn2_first  = 10'b1110010000;
        reset_n     = 1'b0;
        bus.chip_en = 1'b0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.retune  = 1'b0;
        bus.sel_a   = 4'd0;
        bus.sel_b   = 4'd0;
        gen_code(2, 6, 0);
        gen_code(3, 7, 1);
        model_reset();

        // Reset values after release.
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        push_exp("reset_state", 16'h0000, 16'hFFFF, 0, cycle + 1);

        // PRN 1 prefix with early/prompt/late fill.
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd6, 1'b0, "");
        push_exp("prn1_chip0", {1'b1, 2'b00, prn1_first[9], 2'b00, 10'd0}, 16'hFFFF, 0, cycle + 1);
        hand_chips("prn1_chip", prn1_first, 4'd2, 4'd6);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd6, 1'b1, "prn1_chip10");

        // Restart with chip_en in the same cycle, PRN 2, two full epochs.
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd7, 1'b1, "start_with_chip_en");
        push_exp("prn2_chip0", {1'b1, 2'b00, prn2_first[9], 2'b00, 10'd0}, 16'hFFFF, 0, cycle + 1);
        hand_chips("prn2_chip", prn2_first, 4'd3, 4'd7);
        for (int k = 10; k <= 1022; k++)
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd7, 1'b1, "prn2_epoch1");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd7, 1'b1, "prn2_wrap1");
        push_exp("prn2_repeat0", {1'b1, 2'b00, prn2_first[9], 2'b00, 10'd0}, 16'h93FF, 0, cycle + 1);
        for (int k = 1; k <= 1022; k++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd7, 1'b1, "prn2_epoch2");
            if (k < 10)
                push_exp("prn2_repeat", {1'b1, 2'b00, prn2_first[9-k], 2'b00, 10'(k)}, 16'h93FF, 0, cycle + 1);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd7, 1'b1, "prn2_wrap2");

        // Retune at chip 500 takes effect only at the next epoch.
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd6, 1'b1, "retune_start");
        for (int k = 1; k <= 500; k++)
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd6, 1'b1, "retune_head");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd7, 1'b1, "retune_at_500");
        for (int k = 501; k <= 1022; k++)
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "retune_tail");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "retune_wrap");
        push_exp("retune_chip0", {1'b1, 2'b00, 1'b1, 2'b00, 10'd0}, 16'h93FF, 0, cycle + 1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "retune_chip1");
        push_exp("retune_chip1", {1'b1, 2'b00, 1'b1, 2'b00, 10'd1}, 16'h93FF, 0, cycle + 1);

        // Nine epochs back to back; retune coincides with the fifth wrap.
        count_en = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd6, 1'b1, "bits_start");
        for (int ep = 1; ep <= 9; ep++)
            for (int c = 0; c <= 1022; c++)
                apply_stimulus(1'b1, 1'b0, 1'b0, (ep == 5 && c == 1022), 4'd3, 4'd7, 1'b1, "bits_run");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "bits_idle");
        count_en = 1'b0;
        push_exp("epoch_and_bit_edge_count", {8'd9, 8'd3}, 16'hFFFF, 1, cycle + 1);

        // Stop, then chip_en/retune while idle must not advance anything.
        for (int k = 1; k <= 5; k++)
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "pre_stop");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, "stop");
        for (int k = 1; k <= 3; k++)
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd6, 1'b1, "idle_chip_en");

        // Asynchronous reset mid-epoch.
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd6, 1'b1, "reset_test_start");
        for (int k = 1; k <= 300; k++)
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd6, 1'b1, "reset_test_run");
        @(negedge clk);
        bus.chip_en = 1'b1;
        push_exp("async_reset", 16'h0000, 16'hFFFF, 0, cycle);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        push_exp("reset_hold", 16'h0000, 16'hFFFF, 0, cycle + 1);
        @(negedge clk);
        reset_n = 1'b1;
        push_exp("reset_release", 16'h0000, 16'hFFFF, 0, cycle + 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "idle_after_reset");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd7, 1'b1, "start_after_reset");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd7, 1'b1, "chip_after_reset");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "final_idle");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
